mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single core memory port between the IF fetch requester and the MEM load/store requester.
- Sequences one transaction at a time: grant, request handshake, then response wait.
- Drives ram_stall_valid_if / ram_stall_valid_mem into pipeline_control and consumes that block's arb_rdata_ready / arb_wdata_ready response strobes.
- MEM has priority, matching the pipeline rule "later stage wins"; a bounded starvation guard protects IF.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width; strobe width is DATA_W/8
STARVE_MAX, 4, consecutive MEM grants allowed while IF waits, before IF is forced

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-low reset
if_req_i  in  1  fetch request; held with if_addr_i until if_rdata_valid_o
if_addr_i  in  ADDR_W  fetch address
if_flush_i  in  1  fetch killed (jump/trap); discard any pending fetch response
if_rdata_o  out  DATA_W  fetch data
if_rdata_valid_o  out  1  one-cycle fetch completion pulse
mem_req_i  in  1  load/store request; payload held until mem_done_o
mem_we_i  in  1  1 = store
mem_addr_i  in  ADDR_W  access address
mem_wdata_i  in  DATA_W  store data
mem_wstrb_i  in  DATA_W/8  store byte strobes
mem_rdata_o  out  DATA_W  load data
mem_done_o  out  1  one-cycle load/store completion pulse
ram_stall_valid_if_o  out  1  IF stall request to pipeline_control
ram_stall_valid_mem_o  out  1  MEM stall request to pipeline_control
bus_req_valid_o  out  1  downstream request valid
bus_req_ready_i  in  1  downstream request accepted
bus_we_o  out  1  downstream write enable
bus_addr_o  out  ADDR_W  downstream address
bus_wdata_o  out  DATA_W  downstream write data
bus_wstrb_o  out  DATA_W/8  downstream strobes; 0 for reads
bus_rdata_i  in  DATA_W  downstream read data
arb_rdata_ready_i  in  1  read response valid, 1 cycle
arb_wdata_ready_i  in  1  write response valid, 1 cycle

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - All outputs, the starvation counter and the drop flag go to 0.
  - Any in-flight transaction is abandoned.
  - Responses arriving after reset, while not in a WAIT state, are ignored.
- FSM states: IDLE, IF_REQ, IF_WAIT, MEM_REQ, MEM_WAIT.
- IDLE, grant rule:
  - Grant MEM if mem_req_i && !mem_done_o && !(if_req_i && starve_cnt==STARVE_MAX).
  - Otherwise grant IF if if_req_i && !if_rdata_valid_o && !if_flush_i.
  - The granted command (addr, we, wdata, wstrb) is latched at the grant edge.
  - A requester is never re-granted in the cycle its own done pulse is high; this prevents re-issuing a stale payload.
- *_REQ states:
  - bus_req_valid_o=1 with the latched payload; payload is stable until bus_req_ready_i.
  - On bus_req_ready_i, move to *_WAIT and drop bus_req_valid_o in the next cycle.
- IF_WAIT:
  - On arb_rdata_ready_i, capture bus_rdata_i into if_rdata_o and go to IDLE.
  - if_rdata_valid_o pulses 1 the next cycle, unless the drop flag is set.
- MEM_WAIT, read:
  - On arb_rdata_ready_i, capture bus_rdata_i into mem_rdata_o, pulse mem_done_o next cycle, go to IDLE.
- MEM_WAIT, write:
  - On arb_wdata_ready_i, pulse mem_done_o next cycle and go to IDLE; mem_rdata_o is unchanged.
- Responses outside the matching WAIT state are ignored; a wrong-type response in WAIT is ignored.
- Response latency: minimum 3 cycles from grant to done pulse (grant edge, REQ with ready, response in WAIT, pulse).
- Flush handling:
  - if_flush_i in IF_REQ or IF_WAIT sets the drop flag. The bus transaction still completes, since it cannot be aborted.
  - The drop flag clears on return to IDLE, and no if_rdata_valid_o is produced.
  - Flush in IDLE only blocks an IF grant that cycle.
- Starvation counter:
  - Width $clog2(STARVE_MAX+1), saturating.
  - Increments on each MEM grant while if_req_i=1.
  - Clears on IF grant or whenever if_req_i=0.
- Stall outputs (combinational):
  - ram_stall_valid_mem_o = mem_req_i & ~mem_done_o
  - ram_stall_valid_if_o = if_req_i & ~if_rdata_valid_o & ~if_flush_i
- A simultaneous IF and MEM request with starve_cnt < STARVE_MAX grants MEM. IF stays stalled.

Decomposition:
- sysconfig.v gets: the FSM state encodings (3-bit localparams ARB_IDLE..ARB_MEM_WAIT) and the ADDR_W/DATA_W defaults.
- One sub-module, arb_cmd_reg: grant-edge latch of addr/we/wdata/wstrb, plus the response data capture registers.
- FSM, counter and drop flag stay in the top module.

Test Plan:
- IF-only read 0x8000_0000, ready immediate, rdata 0x1122334455667788 two cycles later -> if_rdata_valid_o pulses once with that data; ram_stall_valid_if_o high until the pulse cycle.
- IF and MEM both request in IDLE, MEM store addr 0x8000_1000, wstrb 0x0F -> bus sees we=1, wstrb 0x0F first; mem_done_o pulses after arb_wdata_ready_i; IF is granted afterwards.
- bus_req_ready_i held low 5 cycles in MEM_REQ -> bus_req_valid_o and payload stable all 5 cycles; no done pulse.
- if_flush_i asserted during IF_WAIT -> bus read completes, if_rdata_valid_o never pulses; the next IF request (new address) is granted normally.
- MEM requests back-to-back with IF pending, STARVE_MAX=4 -> exactly 4 MEM grants, then IF granted; counter returns to 0.
- rst=0 for one cycle during MEM_WAIT, then arb_rdata_ready_i arrives -> all outputs 0; the response is ignored; FSM stays in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    // Default bus geometry.
    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 64;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Arbiter FSM encodings (kept 3-bit for legacy compatibility).
    localparam logic [2:0] ARB_IDLE     = 3'd0;
    localparam logic [2:0] ARB_IF_REQ   = 3'd1;
    localparam logic [2:0] ARB_IF_WAIT  = 3'd2;
    localparam logic [2:0] ARB_MEM_REQ  = 3'd3;
    localparam logic [2:0] ARB_MEM_WAIT = 3'd4;

    // Which requester owns the latched command.
    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } arb_src_t;

    // True while the arbiter is presenting a request on the bus.
    function automatic logic is_req_state(input logic [2:0] s);
        return (s == ARB_IF_REQ) || (s == ARB_MEM_REQ);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_cmd_reg.sv
// Grant-edge command latch and response data capture for the port arbiter.
module arb_cmd_reg
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gnt_en,
    input  arb_src_t              gnt_src,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  if_cap,
    input  logic                  mem_cap,
    input  logic [DATA_W-1:0]     rdata,
    output logic                  cmd_we,
    output logic [ADDR_W-1:0]     cmd_addr,
    output logic [DATA_W-1:0]     cmd_wdata,
    output logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic [DATA_W-1:0]     if_rdata,
    output logic [DATA_W-1:0]     mem_rdata
);

    // Latch the granted requester's payload; reads always carry zero strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_wstrb <= '0;
        end else if (gnt_en) begin
            if (gnt_src == SRC_MEM) begin
                cmd_we    <= mem_we;
                cmd_addr  <= mem_addr;
                cmd_wdata <= mem_wdata;
                cmd_wstrb <= mem_we ? mem_wstrb : '0;
            end else begin
                cmd_we    <= 1'b0;
                cmd_addr  <= if_addr;
                cmd_wdata <= '0;
                cmd_wstrb <= '0;
            end
        end
    end

    // Capture read data for whichever requester the response belongs to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if (if_cap)  if_rdata  <= rdata;
            if (mem_cap) mem_rdata <= rdata;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core memory port between IF fetch and MEM load/store.
// MEM wins ties; a saturating counter forces an IF grant after a run of MEM grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    input  logic                  if_flush_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_rdata_valid_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic [DATA_W/8-1:0]   mem_wstrb_i,
    output logic [DATA_W-1:0]     mem_rdata_o,
    output logic                  mem_done_o,
    output logic                  ram_stall_valid_if_o,
    output logic                  ram_stall_valid_mem_o,
    output logic                  bus_req_valid_o,
    input  logic                  bus_req_ready_i,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    output logic [DATA_W/8-1:0]   bus_wstrb_o,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  arb_rdata_ready_i,
    input  logic                  arb_wdata_ready_i
);

    localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             drop;

    logic             if_elig;
    logic             mem_elig;
    logic             gnt_if;
    logic             gnt_mem;
    logic             if_resp;
    logic             mem_resp;
    arb_src_t         gnt_src;

    // Eligibility, grant and response decode.
    always_comb begin
        if_elig  = if_req_i & ~if_rdata_valid_o & ~if_flush_i;
        mem_elig = mem_req_i & ~mem_done_o & ~(if_req_i & (starve_cnt == STARVE_LIM));
        gnt_mem  = (state == ARB_IDLE) & mem_elig;
        gnt_if   = (state == ARB_IDLE) & ~mem_elig & if_elig;
        gnt_src  = gnt_mem ? SRC_MEM : SRC_IF;
        if_resp  = (state == ARB_IF_WAIT) & arb_rdata_ready_i;
        mem_resp = (state == ARB_MEM_WAIT) &
                   (bus_we_o ? arb_wdata_ready_i : arb_rdata_ready_i);
    end

    // Next-state logic: grant, request handshake, response wait.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (gnt_mem)     state_nxt = ARB_MEM_REQ;
                else if (gnt_if) state_nxt = ARB_IF_REQ;
            end
            ARB_IF_REQ:   if (bus_req_ready_i) state_nxt = ARB_IF_WAIT;
            ARB_IF_WAIT:  if (if_resp)         state_nxt = ARB_IDLE;
            ARB_MEM_REQ:  if (bus_req_ready_i) state_nxt = ARB_MEM_WAIT;
            ARB_MEM_WAIT: if (mem_resp)        state_nxt = ARB_IDLE;
            default:                           state_nxt = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= ARB_IDLE;
        else      state <= state_nxt;
    end

    // Completion pulses; a flushed fetch still finishes on the bus but is not reported.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_rdata_valid_o <= 1'b0;
            mem_done_o       <= 1'b0;
        end else begin
            if_rdata_valid_o <= if_resp & ~drop & ~if_flush_i;
            mem_done_o       <= mem_resp;
        end
    end

    // Drop flag: remembers a flush seen while a fetch owns the bus.
    always_ff @(posedge clk) begin
        if (!rst)
            drop <= 1'b0;
        else if (state_nxt == ARB_IDLE)
            drop <= 1'b0;
        else if (((state == ARB_IF_REQ) || (state == ARB_IF_WAIT)) && if_flush_i)
            drop <= 1'b1;
    end

    // Starvation counter: consecutive MEM grants while IF is waiting, saturating.
    always_ff @(posedge clk) begin
        if (!rst)
            starve_cnt <= '0;
        else if (!if_req_i || gnt_if)
            starve_cnt <= '0;
        else if (gnt_mem && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 1'b1;
    end

    arb_cmd_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmd_reg (
        .clk       (clk),
        .rst       (rst),
        .gnt_en    (gnt_mem | gnt_if),
        .gnt_src   (gnt_src),
        .if_addr   (if_addr_i),
        .mem_we    (mem_we_i),
        .mem_addr  (mem_addr_i),
        .mem_wdata (mem_wdata_i),
        .mem_wstrb (mem_wstrb_i),
        .if_cap    (if_resp),
        .mem_cap   (mem_resp & ~bus_we_o),
        .rdata     (bus_rdata_i),
        .cmd_we    (bus_we_o),
        .cmd_addr  (bus_addr_o),
        .cmd_wdata (bus_wdata_o),
        .cmd_wstrb (bus_wstrb_o),
        .if_rdata  (if_rdata_o),
        .mem_rdata (mem_rdata_o)
    );

    assign bus_req_valid_o       = is_req_state(state);
    assign ram_stall_valid_mem_o = mem_req_i & ~mem_done_o;
    assign ram_stall_valid_if_o  = if_req_i & ~if_rdata_valid_o & ~if_flush_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i, if_flush_i, mem_req_i, mem_we_i;
    logic [ADDR_W-1:0] if_addr_i, mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i, bus_rdata_i;
    logic [STRB_W-1:0] mem_wstrb_i;
    logic              bus_req_ready_i, arb_rdata_ready_i, arb_wdata_ready_i;
    logic [DATA_W-1:0] if_rdata_o, mem_rdata_o, bus_wdata_o;
    logic              if_rdata_valid_o, mem_done_o, bus_req_valid_o, bus_we_o;
    logic              ram_stall_valid_if_o, ram_stall_valid_mem_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [STRB_W-1:0] bus_wstrb_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .if_req_i              (if_req_i),
        .if_addr_i             (if_addr_i),
        .if_flush_i            (if_flush_i),
        .if_rdata_o            (if_rdata_o),
        .if_rdata_valid_o      (if_rdata_valid_o),
        .mem_req_i             (mem_req_i),
        .mem_we_i              (mem_we_i),
        .mem_addr_i            (mem_addr_i),
        .mem_wdata_i           (mem_wdata_i),
        .mem_wstrb_i           (mem_wstrb_i),
        .mem_rdata_o           (mem_rdata_o),
        .mem_done_o            (mem_done_o),
        .ram_stall_valid_if_o  (ram_stall_valid_if_o),
        .ram_stall_valid_mem_o (ram_stall_valid_mem_o),
        .bus_req_valid_o       (bus_req_valid_o),
        .bus_req_ready_i       (bus_req_ready_i),
        .bus_we_o              (bus_we_o),
        .bus_addr_o            (bus_addr_o),
        .bus_wdata_o           (bus_wdata_o),
        .bus_wstrb_o           (bus_wstrb_o),
        .bus_rdata_i           (bus_rdata_i),
        .arb_rdata_ready_i     (arb_rdata_ready_i),
        .arb_wdata_ready_i     (arb_wdata_ready_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        if_req_i = 0; if_flush_i = 0; if_addr_i = '0;
        mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
        bus_req_ready_i = 0; arb_rdata_ready_i = 0; arb_wdata_ready_i = 0; bus_rdata_i = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 0;
        tick();
        tick();
        checks++;
        if ({if_rdata_o, if_rdata_valid_o, mem_rdata_o, mem_done_o, ram_stall_valid_if_o,
             ram_stall_valid_mem_o, bus_req_valid_o, bus_we_o, bus_addr_o, bus_wdata_o,
             bus_wstrb_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b addr=%h done=%b ifv=%b, want all zero",
                     bus_req_valid_o, bus_addr_o, mem_done_o, if_rdata_valid_o);
        end
        rst = 1;
        tick();
    endtask

    task automatic test_if_read;
        if_req_i = 1; if_addr_i = 32'h8000_0000;
        #1;
        checks++;
        if (ram_stall_valid_if_o !== 1'b1) begin
            errors++; $display("FAIL if_stall_req: got %b want 1", ram_stall_valid_if_o);
        end
        tick();
        checks++;
        if (bus_req_valid_o !== 1'b1 || bus_addr_o !== 32'h8000_0000 || bus_we_o !== 1'b0 ||
            bus_wstrb_o !== 8'h00) begin
            errors++;
            $display("FAIL if_grant: valid=%b addr=%h we=%b strb=%h want 1 80000000 0 00",
                     bus_req_valid_o, bus_addr_o, bus_we_o, bus_wstrb_o);
        end
        bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0;
        checks++;
        if (bus_req_valid_o !== 1'b0 || ram_stall_valid_if_o !== 1'b1) begin
            errors++;
            $display("FAIL if_wait: valid=%b stall=%b want 0 1", bus_req_valid_o, ram_stall_valid_if_o);
        end
        tick();
        arb_rdata_ready_i = 1; bus_rdata_i = 64'h1122_3344_5566_7788;
        tick();
        arb_rdata_ready_i = 0;
        checks++;
        if (if_rdata_valid_o !== 1'b1 || if_rdata_o !== 64'h1122_3344_5566_7788 ||
            ram_stall_valid_if_o !== 1'b0) begin
            errors++;
            $display("FAIL if_pulse: v=%b data=%h stall=%b want 1 1122334455667788 0",
                     if_rdata_valid_o, if_rdata_o, ram_stall_valid_if_o);
        end
        if_req_i = 0;
        tick();
        checks++;
        if (if_rdata_valid_o !== 1'b0) begin
            errors++; $display("FAIL if_pulse_once: got %b want 0", if_rdata_valid_o);
        end
    endtask

    task automatic test_mem_priority;
        if_req_i = 1; if_addr_i = 32'h8000_0040;
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h8000_1000;
        mem_wdata_i = 64'hDEAD_BEEF_0BAD_F00D; mem_wstrb_i = 8'h0F;
        tick();
        checks++;
        if (bus_req_valid_o !== 1'b1 || bus_we_o !== 1'b1 || bus_addr_o !== 32'h8000_1000 ||
            bus_wstrb_o !== 8'h0F || bus_wdata_o !== 64'hDEAD_BEEF_0BAD_F00D) begin
            errors++;
            $display("FAIL prio_mem_first: valid=%b we=%b addr=%h strb=%h want 1 1 80001000 0f",
                     bus_req_valid_o, bus_we_o, bus_addr_o, bus_wstrb_o);
        end
        checks++;
        if (ram_stall_valid_if_o !== 1'b1 || ram_stall_valid_mem_o !== 1'b1) begin
            errors++;
            $display("FAIL prio_stalls: if=%b mem=%b want 1 1", ram_stall_valid_if_o, ram_stall_valid_mem_o);
        end
        bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0;
        arb_rdata_ready_i = 1;
        tick();
        arb_rdata_ready_i = 0;
        checks++;
        if (mem_done_o !== 1'b0 || bus_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL prio_wrong_resp: done=%b valid=%b want 0 0", mem_done_o, bus_req_valid_o);
        end
        arb_wdata_ready_i = 1;
        tick();
        arb_wdata_ready_i = 0;
        checks++;
        if (mem_done_o !== 1'b1 || mem_rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL prio_store_done: done=%b rdata=%h want 1 0", mem_done_o, mem_rdata_o);
        end
        mem_req_i = 0;
        tick();
        checks++;
        if (bus_req_valid_o !== 1'b1 || bus_addr_o !== 32'h8000_0040 || bus_we_o !== 1'b0 ||
            bus_wstrb_o !== 8'h00 || mem_done_o !== 1'b0) begin
            errors++;
            $display("FAIL prio_if_after: valid=%b addr=%h we=%b done=%b want 1 80000040 0 0",
                     bus_req_valid_o, bus_addr_o, bus_we_o, mem_done_o);
        end
        bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0;
        arb_rdata_ready_i = 1; bus_rdata_i = 64'h0123_4567_89AB_CDEF;
        tick();
        arb_rdata_ready_i = 0;
        checks++;
        if (if_rdata_valid_o !== 1'b1 || if_rdata_o !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL prio_if_data: v=%b data=%h want 1 0123456789abcdef", if_rdata_valid_o, if_rdata_o);
        end
        if_req_i = 0;
        tick();
    endtask

    task automatic test_ready_hold;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_2000;
        mem_wdata_i = 64'h5A5A_5A5A_5A5A_5A5A; mem_wstrb_i = 8'hFF;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus_req_valid_o !== 1'b1 || bus_addr_o !== 32'h8000_2000 || bus_we_o !== 1'b0 ||
                bus_wstrb_o !== 8'h00 || mem_done_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b addr=%h we=%b strb=%h done=%b want 1 80002000 0 00 0",
                         i, bus_req_valid_o, bus_addr_o, bus_we_o, bus_wstrb_o, mem_done_o);
            end
            arb_rdata_ready_i = (i == 2);
            if (i < 4) tick();
        end
        arb_rdata_ready_i = 0;
        bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0;
        arb_rdata_ready_i = 1; bus_rdata_i = 64'hCAFE_F00D_1234_5678;
        tick();
        arb_rdata_ready_i = 0;
        checks++;
        if (mem_done_o !== 1'b1 || mem_rdata_o !== 64'hCAFE_F00D_1234_5678) begin
            errors++;
            $display("FAIL hold_load_done: done=%b rdata=%h want 1 cafef00d12345678", mem_done_o, mem_rdata_o);
        end
        mem_req_i = 0;
        tick();
        checks++;
        if (mem_done_o !== 1'b0) begin
            errors++; $display("FAIL hold_done_once: got %b want 0", mem_done_o);
        end
    endtask

    task automatic test_flush;
        if_req_i = 1; if_addr_i = 32'h8000_3000;
        tick();
        bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0;
        if_flush_i = 1; if_addr_i = 32'h8000_3100;
        tick();
        if_flush_i = 0;
        arb_rdata_ready_i = 1; bus_rdata_i = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        arb_rdata_ready_i = 0;
        checks++;
        if (if_rdata_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_drop: valid=%b want 0", if_rdata_valid_o);
        end
        tick();
        checks++;
        if (if_rdata_valid_o !== 1'b0 || bus_req_valid_o !== 1'b1 || bus_addr_o !== 32'h8000_3100) begin
            errors++;
            $display("FAIL flush_regrant: ifv=%b valid=%b addr=%h want 0 1 80003100",
                     if_rdata_valid_o, bus_req_valid_o, bus_addr_o);
        end
        bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0;
        arb_rdata_ready_i = 1; bus_rdata_i = 64'h5555_6666_7777_8888;
        tick();
        arb_rdata_ready_i = 0;
        checks++;
        if (if_rdata_valid_o !== 1'b1 || if_rdata_o !== 64'h5555_6666_7777_8888) begin
            errors++;
            $display("FAIL flush_next_data: v=%b data=%h want 1 5555666677778888", if_rdata_valid_o, if_rdata_o);
        end
        if_req_i = 0;
        tick();
    endtask

    task automatic test_starvation;
        logic [ADDR_W-1:0] base;
        base = 32'h8000_5000;
        if_req_i = 1; if_addr_i = 32'h8000_4000;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = base;
        for (int unsigned g = 0; g < STARVE_MAX; g++) begin
            tick();
            checks++;
            if (bus_req_valid_o !== 1'b1 || bus_addr_o !== base + 32'(g * 8) || bus_we_o !== 1'b0) begin
                errors++;
                $display("FAIL starve_mem_grant%0d: valid=%b addr=%h want 1 %h",
                         g, bus_req_valid_o, bus_addr_o, base + 32'(g * 8));
            end
            bus_req_ready_i = 1;
            tick();
            bus_req_ready_i = 0;
            arb_rdata_ready_i = 1; bus_rdata_i = 64'(g);
            tick();
            arb_rdata_ready_i = 0;
            mem_addr_i = base + 32'((g + 1) * 8);
            if_flush_i = 1;
            tick();
            if_flush_i = 0;
        end
        checks++;
        if (dut.starve_cnt !== 3'd4) begin
            errors++; $display("FAIL starve_cnt_full: got %0d want 4", dut.starve_cnt);
        end
        tick();
        checks++;
        if (bus_req_valid_o !== 1'b1 || bus_addr_o !== 32'h8000_4000 || bus_we_o !== 1'b0 ||
            dut.starve_cnt !== 3'd0) begin
            errors++;
            $display("FAIL starve_if_forced: valid=%b addr=%h cnt=%0d want 1 80004000 0",
                     bus_req_valid_o, bus_addr_o, dut.starve_cnt);
        end
        mem_req_i = 0;
        bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0;
        arb_rdata_ready_i = 1; bus_rdata_i = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        arb_rdata_ready_i = 0;
        checks++;
        if (if_rdata_valid_o !== 1'b1 || if_rdata_o !== 64'h0F0F_0F0F_0F0F_0F0F) begin
            errors++;
            $display("FAIL starve_if_data: v=%b data=%h want 1 0f0f0f0f0f0f0f0f", if_rdata_valid_o, if_rdata_o);
        end
        if_req_i = 0;
        tick();
    endtask

    task automatic test_reset_in_wait;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_6000;
        tick();
        bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0;
        rst = 0; mem_req_i = 0;
        tick();
        rst = 1;
        arb_rdata_ready_i = 1; bus_rdata_i = 64'hFFFF_0000_FFFF_0000;
        tick();
        arb_rdata_ready_i = 0;
        checks++;
        if ({if_rdata_o, if_rdata_valid_o, mem_rdata_o, mem_done_o, bus_req_valid_o, bus_we_o,
             bus_addr_o, bus_wdata_o, bus_wstrb_o} !== '0 || dut.state !== ARB_IDLE) begin
            errors++;
            $display("FAIL reset_wait_ignored: done=%b rdata=%h valid=%b state=%0d want 0 0 0 %0d",
                     mem_done_o, mem_rdata_o, bus_req_valid_o, dut.state, ARB_IDLE);
        end
        tick();
    endtask

    task automatic test_random(input int unsigned ncyc);
        logic              busy, acc, own_mem, drop, m_we;
        logic [ADDR_W-1:0] m_addr;
        logic [DATA_W-1:0] m_wdata, exp_ifd, exp_mdd;
        logic [STRB_W-1:0] m_wstrb;
        logic              exp_ifv, exp_md, nxt_ifv, nxt_md, mem_ok, if_ok;
        int unsigned       cnt;
        clear_inputs();
        rst = 0;
        tick();
        rst = 1;
        busy = 0; acc = 0; own_mem = 0; drop = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0;
        exp_ifv = 0; exp_md = 0; exp_ifd = '0; exp_mdd = '0; cnt = 0;
        for (int unsigned c = 0; c < ncyc; c++) begin
            tick();
            checks++;
            if (bus_req_valid_o !== (busy && !acc)) begin
                errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus_req_valid_o, busy && !acc);
            end
            if (busy && !acc) begin
                checks++;
                if (bus_we_o !== m_we || bus_addr_o !== m_addr || bus_wstrb_o !== m_wstrb ||
                    (m_we && bus_wdata_o !== m_wdata)) begin
                    errors++;
                    $display("FAIL rnd_payload c%0d: we=%b addr=%h strb=%h want %b %h %h",
                             c, bus_we_o, bus_addr_o, bus_wstrb_o, m_we, m_addr, m_wstrb);
                end
            end
            checks++;
            if (if_rdata_valid_o !== exp_ifv || mem_done_o !== exp_md ||
                if_rdata_o !== exp_ifd || mem_rdata_o !== exp_mdd) begin
                errors++;
                $display("FAIL rnd_resp c%0d: ifv=%b done=%b ifd=%h md=%h want %b %b %h %h", c,
                         if_rdata_valid_o, mem_done_o, if_rdata_o, mem_rdata_o, exp_ifv, exp_md, exp_ifd, exp_mdd);
            end
            // requesters: new request only after completion, flush, or while idle
            if (exp_ifv || if_flush_i || !if_req_i) begin
                if_req_i = ($urandom % 4) != 0;
                if_addr_i = $urandom & 32'hFFFF_FFF8;
            end
            if_flush_i = if_req_i && (($urandom % 12) == 0);
            if (exp_md || !mem_req_i) begin
                mem_req_i = ($urandom % 3) != 0;
                mem_we_i = 1'($urandom % 2);
                mem_addr_i = $urandom & 32'hFFFF_FFF8;
                mem_wdata_i = {$urandom, $urandom};
                mem_wstrb_i = 8'($urandom);
            end
            // downstream: random ready, random responses including wrong-type and stray ones
            bus_req_ready_i = 1'($urandom % 2);
            bus_rdata_i = {$urandom, $urandom};
            arb_rdata_ready_i = 0; arb_wdata_ready_i = 0;
            if (busy && acc) begin
                case ($urandom % 6)
                    0, 1: begin
                        arb_wdata_ready_i = own_mem && m_we;
                        arb_rdata_ready_i = !(own_mem && m_we);
                    end
                    2: begin
                        arb_wdata_ready_i = !(own_mem && m_we);
                        arb_rdata_ready_i = own_mem && m_we;
                    end
                    default: ;
                endcase
            end else if (($urandom % 10) == 0) begin
                arb_rdata_ready_i = 1'($urandom % 2);
                arb_wdata_ready_i = !arb_rdata_ready_i;
            end
            #1;
            checks++;
            if (ram_stall_valid_if_o !== (if_req_i && !exp_ifv && !if_flush_i) ||
                ram_stall_valid_mem_o !== (mem_req_i && !exp_md)) begin
                errors++;
                $display("FAIL rnd_stall c%0d: if=%b mem=%b", c, ram_stall_valid_if_o, ram_stall_valid_mem_o);
            end
            // reference model: what the next edge must do
            nxt_ifv = 0; nxt_md = 0;
            if (!busy) begin
                mem_ok = mem_req_i && !exp_md && !(if_req_i && cnt == STARVE_MAX);
                if_ok  = if_req_i && !exp_ifv && !if_flush_i;
                acc = 0; drop = 0;
                if (mem_ok) begin
                    busy = 1; own_mem = 1;
                    m_we = mem_we_i; m_addr = mem_addr_i; m_wdata = mem_wdata_i;
                    m_wstrb = mem_we_i ? mem_wstrb_i : '0;
                    if (if_req_i && cnt < STARVE_MAX) cnt++;
                end else if (if_ok) begin
                    busy = 1; own_mem = 0;
                    m_we = 0; m_addr = if_addr_i; m_wstrb = '0;
                    cnt = 0;
                end
            end else if (!acc) begin
                if (!own_mem && if_flush_i) drop = 1;
                if (bus_req_ready_i) acc = 1;
            end else if (!own_mem) begin
                if (arb_rdata_ready_i) begin
                    busy = 0; exp_ifd = bus_rdata_i; nxt_ifv = !(drop || if_flush_i);
                end else if (if_flush_i) begin
                    drop = 1;
                end
            end else if (m_we ? arb_wdata_ready_i : arb_rdata_ready_i) begin
                busy = 0; nxt_md = 1;
                if (!m_we) exp_mdd = bus_rdata_i;
            end
            if (!if_req_i) cnt = 0;
            exp_ifv = nxt_ifv; exp_md = nxt_md;
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_priority();
        test_ready_hold();
        test_flush();
        test_starvation();
        test_reset_in_wait();
        test_random(4000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
